// File: rtl/syscall_pkg.sv
// Shared service codes, FSM state encoding and ASCII helpers for the syscall unit.
// Latency: none (types/constants only); backpressure: not applicable.
package syscall_pkg;

  localparam int SYS_PRINT_INT  = 1;
  localparam int SYS_PRINT_STR  = 4;
  localparam int SYS_EXIT       = 10;
  localparam int SYS_PRINT_CHAR = 11;
  localparam int SYS_PRINT_HEX  = 34;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_A_LC  = 8'h61;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_EMIT_INT,
    S_STR_RD,
    S_STR_EMIT,
    S_EMIT_CHAR,
    S_DONE,
    S_HALT
  } state_t;

  // Decimal digits needed for a w-bit unsigned value (log10(2) ~ 0.30103).
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A_LC - 8'd10 + {4'h0, n});
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: DATA_W-bit binary to DIGITS BCD digits, one shift per cycle.
// Latency: o_done high DATA_W cycles after i_start (first shift happens on the start edge); no backpressure.
module bin2bcd_seq #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_bin;
  logic [4*DIGITS-1:0] r_bcd;

  logic [DATA_W-1:0]   w_bin_src;
  logic [4*DIGITS-1:0] w_bcd_src;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_bcd_nxt;

  always_comb begin
    w_bin_src = i_start ? i_bin : r_bin;
    w_bcd_src = i_start ? '0 : r_bcd;
    w_adj     = w_bcd_src;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd_src[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = w_bcd_src[4*i +: 4] + 4'd3;
    end
    // The top adjusted bit can never be set for a correctly sized digit count.
    w_bcd_nxt = (4*DIGITS)'({w_adj, w_bin_src[DATA_W-1]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(DATA_W - 1);
      r_bin  <= w_bin_src << 1;
      r_bcd  <= w_bcd_nxt;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_bin <= w_bin_src << 1;
        r_bcd <= w_bcd_nxt;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy & (r_cnt != '0);
  assign o_done = r_busy & (r_cnt == '0);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/syscall_unit.sv
// Syscall execution unit: print-int/str/char, exit (sticky halt); SYSCALL_HEX_EN adds print-hex (code 34).
// Latency: char byte 1 cycle after accept, int DATA_W+1; console bytes held until out_ready, pipeline stalled via sys_busy.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_STR_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys_req,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              sys_busy,
  output logic              sys_done,
  output logic              halt,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic [7:0]        mem_rd_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready
);

  localparam int DIGITS     = bcd_digits(DATA_W);
  localparam int HEX_DIGITS = DATA_W / 4;
  localparam int IDX_W      = $clog2(MAX_STR_LEN + 1);

  state_t              r_state;
  logic                r_done, r_halt, r_rd_req, r_out_vld;
  logic [7:0]          r_out_dat;
  logic [ADDR_W-1:0]   r_addr, r_base;
  logic [IDX_W-1:0]    r_sidx;
  logic [7:0]          r_idx;
  logic                r_more, r_pre, r_neg, r_hex;
  logic [DATA_W-1:0]   r_mag;

  logic                w_conv_start, w_conv_busy, w_conv_done;
  logic [DATA_W-1:0]   w_mag;
  logic [4*DIGITS-1:0] w_bcd;
  logic [3:0]          w_dig, w_lead_dig;
  logic [7:0]          w_lead, w_dig_chr;
  logic [IDX_W-1:0]    w_sidx_n;

  assign w_conv_start = (r_state == S_IDLE) & sys_req & (v0 == DATA_W'(SYS_PRINT_INT));
  assign w_mag        = a0[DATA_W-1] ? -a0 : a0;
  assign w_sidx_n     = r_sidx + IDX_W'(1);

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_conv_start),
    .i_bin   (w_mag),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  // r_idx walks down from the most significant printed digit/nibble.
  always_comb begin
    w_dig      = '0;
    w_lead     = '0;
    w_lead_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_hex && r_idx == 8'(i)) w_dig = w_bcd[4*i +: 4];
      if (w_bcd[4*i +: 4] != 4'd0) begin
        w_lead     = 8'(i);
        w_lead_dig = w_bcd[4*i +: 4];
      end
    end
    for (int i = 0; i < HEX_DIGITS; i++) begin
      if (r_hex && r_idx == 8'(i)) w_dig = r_mag[4*i +: 4];
    end
    w_dig_chr = r_hex ? hex_chr(w_dig) : (ASCII_0 + {4'h0, w_dig});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_halt    <= 1'b0;
      r_rd_req  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_addr    <= '0;
      r_base    <= '0;
      r_sidx    <= '0;
      r_idx     <= '0;
      r_more    <= 1'b0;
      r_pre     <= 1'b0;
      r_neg     <= 1'b0;
      r_hex     <= 1'b0;
      r_mag     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (sys_req) begin
          r_mag <= a0;
          r_neg <= a0[DATA_W-1];
          r_hex <= 1'b0;
          case (v0)
            DATA_W'(SYS_PRINT_INT): r_state <= S_CONV;
            DATA_W'(SYS_PRINT_STR): begin
              r_state  <= S_STR_RD;
              r_rd_req <= 1'b1;
              r_addr   <= ADDR_W'(a0);
              r_base   <= ADDR_W'(a0);
              r_sidx   <= '0;
            end
            DATA_W'(SYS_PRINT_CHAR): begin
              r_state   <= S_EMIT_CHAR;
              r_out_vld <= 1'b1;
              r_out_dat <= a0[7:0];
            end
            DATA_W'(SYS_EXIT): begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
              r_done  <= 1'b1;
            end
`ifdef SYSCALL_HEX_EN
            DATA_W'(SYS_PRINT_HEX): begin
              r_state   <= S_EMIT_INT;
              r_hex     <= 1'b1;
              r_pre     <= 1'b1;
              r_more    <= 1'b1;
              r_idx     <= 8'(HEX_DIGITS - 1);
              r_out_vld <= 1'b1;
              r_out_dat <= ASCII_0;
            end
`endif
            default: begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          endcase
        end
        S_CONV: if (w_conv_done) begin
          r_state   <= S_EMIT_INT;
          r_out_vld <= 1'b1;
          if (r_neg) begin
            r_out_dat <= ASCII_MINUS;
            r_idx     <= w_lead;
            r_more    <= 1'b1;
          end else begin
            r_out_dat <= ASCII_0 + {4'h0, w_lead_dig};
            r_idx     <= w_lead - 8'd1;
            r_more    <= (w_lead != 8'd0);
          end
        end else if (!w_conv_busy) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_EMIT_INT: if (out_ready) begin
          if (r_pre) begin
            r_out_dat <= ASCII_X;
            r_pre     <= 1'b0;
          end else if (r_more) begin
            r_out_dat <= w_dig_chr;
            r_more    <= (r_idx != 8'd0);
            r_idx     <= r_idx - 8'd1;
          end else begin
            r_out_vld <= 1'b0;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
          end
        end
        S_STR_RD: if (mem_rd_ack) begin
          r_rd_req <= 1'b0;
          if (mem_rd_data == 8'h00) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_STR_EMIT;
            r_out_vld <= 1'b1;
            r_out_dat <= mem_rd_data;
          end
        end
        S_STR_EMIT: if (out_ready) begin
          r_out_vld <= 1'b0;
          r_sidx    <= w_sidx_n;
          if (w_sidx_n == IDX_W'(MAX_STR_LEN)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= S_STR_RD;
            r_rd_req <= 1'b1;
            r_addr   <= r_base + ADDR_W'(w_sidx_n);
          end
        end
        S_EMIT_CHAR: if (out_ready) begin
          r_out_vld <= 1'b0;
          r_state   <= S_DONE;
          r_done    <= 1'b1;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_HALT:  r_done  <= 1'b0;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sys_busy   = r_halt | ((r_state != S_IDLE) & ~r_done) | ((r_state == S_IDLE) & sys_req);
  assign sys_done   = r_done;
  assign halt       = r_halt;
  assign mem_rd_req = r_rd_req;
  assign mem_addr   = r_addr;
  assign out_valid  = r_out_vld;
  assign out_data   = r_out_dat;

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: expected console bytes come from a decimal/string/char model queue,
// checked on every accepted byte, plus literal strings, latencies, halt and mid-service reset cases.
module tb_syscall_unit;

  logic        clk;
  logic        rst_n;
  logic        sys_req;
  logic [31:0] v0, a0;
  logic        sys_busy, sys_done, halt, mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  syscall_unit #(.DATA_W(32), .ADDR_W(32), .MAX_STR_LEN(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sys_req     (sys_req),
    .v0          (v0),
    .a0          (a0),
    .sys_busy    (sys_busy),
    .sys_done    (sys_done),
    .halt        (halt),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mem [0:1023];
  logic [7:0]  exp_q [$];
  string       got_s;
  int          stall_left;
  int          ack_delay;
  int          wait_cnt;
  logic [31:0] rd_base;
  int          rd_count;
  logic        prev_hold;
  logic [7:0]  prev_dat;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_str(input string nm, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  // Reference: what the console must print for a given service.
  function automatic void model_push(input int code, input logic [31:0] a);
    longint     v;
    logic [7:0] d [$];
    logic       stop;
    case (code)
      1: begin
        v = longint'($signed(a));
        if (v < 0) begin
          exp_q.push_back(8'h2D);
          v = -v;
        end
        do begin
          d.push_front(8'(48 + v % 10));
          v = v / 10;
        end while (v > 0);
        foreach (d[i]) exp_q.push_back(d[i]);
      end
      4: begin
        stop = 1'b0;
        for (int i = 0; i < 256 && !stop; i++) begin
          if (mem[10'(a + 32'(i))] == 8'h00) stop = 1'b1;
          else exp_q.push_back(mem[10'(a + 32'(i))]);
        end
      end
      11: exp_q.push_back(a[7:0]);
`ifdef SYSCALL_HEX_EN
      34: begin
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        for (int i = 7; i >= 0; i--) begin
          logic [3:0] nb;
          nb = a[4*i +: 4];
          exp_q.push_back((nb < 4'd10) ? (8'd48 + {4'h0, nb}) : (8'd87 + {4'h0, nb}));
        end
      end
`endif
      default: ;
    endcase
  endfunction

  // Console sink: holds out_ready low for stall_left cycles of valid data.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && out_valid) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Memory: acks after ack_delay waiting cycles and checks the requested address.
  initial begin
    mem_rd_ack  = 1'b0;
    mem_rd_data = 8'h00;
    wait_cnt    = 0;
    forever begin
      @(posedge clk); #1;
      mem_rd_ack = 1'b0;
      if (!mem_rd_req) wait_cnt = 0;
      else if (wait_cnt >= ack_delay) begin
        check("mem_addr", mem_addr, rd_base + 32'(rd_count));
        mem_rd_ack  = 1'b1;
        mem_rd_data = mem[mem_addr[9:0]];
        rd_count++;
        wait_cnt = 0;
      end else wait_cnt++;
    end
  end

  // Every accepted byte is compared against the model; stalled bytes must not change.
  always @(negedge clk) begin
    if (!rst_n) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_dat);
      end
      if (out_valid && out_ready) begin
        got_s = $sformatf("%s%c", got_s, out_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got 0x%0h expected no byte", out_data);
        end else check("byte", out_data, exp_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_dat  = out_data;
    end
  end

  task automatic run_svc(input int code, input logic [31:0] arg, input int stall, input int dly,
                         input string exp_str, input int exp_lat);
    int n, first, busy_drop;
    exp_q.delete();
    model_push(code, arg);
    got_s = ""; rd_base = arg; rd_count = 0; ack_delay = dly; stall_left = stall;
    @(posedge clk); #1;
    sys_req = 1'b1; v0 = 32'(code); a0 = arg;
    #1 check("busy_on_req", sys_busy, 1);
    n = 0; first = -1; busy_drop = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (out_valid && first < 0) first = n;
      if (!sys_done && !sys_busy) busy_drop++;
    end while (!sys_done && n < 3000);
    check("sys_done_seen", sys_done, 1);
    check("busy_at_done", sys_busy, (code == 10));
    check("busy_throughout", busy_drop, 0);
    if (exp_lat >= 0) check("first_byte_latency", first, exp_lat);
    sys_req = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", sys_done, 0);
    check("bytes_missing", exp_q.size(), 0);
    if (exp_str != "*") check_str("console_text", got_s, exp_str);
  endtask

  task automatic abort_str(input int stall, input bit on_vld);
    int n;
    exp_q.delete();
    model_push(4, 32'd512);
    got_s = ""; rd_base = 32'd512; rd_count = 0; ack_delay = 3; stall_left = stall;
    @(posedge clk); #1;
    sys_req = 1'b1; v0 = 32'd4; a0 = 32'd512;
    n = 0;
    while (n < 200 && !(on_vld ? out_valid : (mem_rd_req && rd_count >= 2))) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_point_reached", (n < 200), 1);
    #2 rst_n = 1'b0; sys_req = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_mem_rd_req", mem_rd_req, 0);
    check("abort_sys_done", sys_done, 0);
    check("abort_sys_busy", sys_busy, 0);
    exp_q.delete();
    stall_left = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; sys_req = 1'b0; v0 = '0; a0 = '0;
    stall_left = 0; ack_delay = 0; rd_base = '0; rd_count = 0; got_s = "";
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16] = 8'h48; mem[17] = 8'h69; mem[18] = 8'h00;
    for (int i = 0; i < 300; i++) mem[512 + i] = 8'(97 + i % 26);

    repeat (3) @(posedge clk); #1;
    check("rst_sys_done", sys_done, 0);
    check("rst_halt", halt, 0);
    check("rst_mem_rd_req", mem_rd_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sys_busy", sys_busy, 0);
    rst_n = 1'b1;

    run_svc(1, -32'sd123, 0, 0, "-123", 33);
    run_svc(1, 32'd0, 0, 0, "0", 33);
    run_svc(1, 32'h8000_0000, 0, 0, "-2147483648", 33);
    run_svc(1, 32'd2147483647, 3, 0, "2147483647", 33);
    run_svc(1, 32'd1000000000, 1, 0, "1000000000", 33);
    run_svc(4, 32'd16, 0, 3, "Hi", -1);
    check("hi_reads", rd_count, 3);
    run_svc(4, 32'd100, 0, 0, "", -1);
    check("empty_str_reads", rd_count, 1);
    run_svc(4, 32'd512, 0, 1, "*", -1);
    check("long_str_len", got_s.len(), 256);
    check("long_str_reads", rd_count, 256);
    run_svc(11, 32'h41, 5, 0, "A", 1);
    run_svc(11, 32'hFFFF_FF7A, 0, 0, "z", 1);
    run_svc(5, 32'd7, 0, 0, "", -1);
`ifdef SYSCALL_HEX_EN
    run_svc(34, 32'h00ab12cd, 0, 0, "0x00ab12cd", -1);
`else
    run_svc(34, 32'h00ab12cd, 0, 0, "", -1);
`endif

    abort_str(1000, 1'b1);
    abort_str(0, 1'b0);
    run_svc(11, 32'h5A, 0, 0, "Z", 1);

    run_svc(10, 32'd0, 0, 0, "", -1);
    check("halt_set", halt, 1);
    exp_q.delete();
    sys_req = 1'b1; v0 = 32'd11; a0 = 32'h51;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sys_done || out_valid || !halt || !sys_busy) bad++;
    end
    check("halt_sticky_ignores_req", bad, 0);
    sys_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("halt_cleared_by_reset", halt, 0);
    check("busy_after_halt_reset", sys_busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_svc(1, 32'd42, 0, 0, "42", 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
